// File: rtl/cnt_seq_pkg.sv
// rtl/cnt_seq_pkg.sv - shared constants for the counter sequencer
// Purpose: opcode values, FSM state encoding and the default prescale
//          constant used by counter_sequencer and tick_prescaler.
// Ports:   none (package).
package cnt_seq_pkg;

  localparam int CLK_HZ           = 12_000_000;
  localparam int PRESCALE_DEFAULT = CLK_HZ / 1000;  // 1 kHz count tick

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_START   = 2'b01;
  localparam logic [1:0] OP_STOP    = 2'b10;
  localparam logic [1:0] OP_ONESHOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OS   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides hw_clk down to a single-cycle count tick
// Purpose: counts 0..PRESCALE-1 while en is high and flags the last count.
// Ports:
//   hw_clk  in  system clock
//   rst     in  asynchronous active-low reset
//   en      in  advance the count
//   clr     in  force the count to 0 (wins over en)
//   tick    out high while count == PRESCALE-1 and en is high
module tick_prescaler #(
  parameter int PRESCALE = 12000,
  parameter int PS_W     = 14
) (
  input  logic hw_clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  always_ff @(posedge hw_clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command-driven sequencer for the board counter
// Purpose: accepts LOAD/START/STOP/ONESHOT commands and steps q on each
//          prescaled tick; a one-shot stops at its terminal value and
//          pulses done. Optional macro CNT_SEQ_DOWN_EN adds the cnt_dir
//          input for down-counting.
// Ports:
//   hw_clk     in   system clock (12 MHz)
//   rst        in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted when cmd_valid && cmd_ready
//   cmd_op     in   00 LOAD, 01 START, 10 STOP, 11 ONESHOT
//   cmd_data   in   LOAD value / ONESHOT terminal value
//   cnt_dir    in   0 up, 1 down (CNT_SEQ_DOWN_EN only)
//   q          out  counter value
//   running    out  high in RUN or OS
//   done       out  one-cycle pulse when a one-shot completes
module counter_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PS_W     = 14
) (
  input  logic             hw_clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
`ifdef CNT_SEQ_DOWN_EN
  input  logic             cnt_dir,
`endif
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic             done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] term, term_next;
  logic [WIDTH-1:0] q_step;
  logic             active;
  logic             accept;
  logic             tick;

  assign active    = (state == S_RUN) || (state == S_OS);
  assign cmd_ready = (state != S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign running   = active;
  assign done      = (state == S_DONE);

`ifdef CNT_SEQ_DOWN_EN
  assign q_step = cnt_dir ? q - 1'b1 : q + 1'b1;
`else
  assign q_step = q + 1'b1;
`endif

  // Any accepted command restarts the tick period, so a command landing on
  // a tick cycle swallows that tick. Idle/done keep the prescaler at 0.
  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .hw_clk (hw_clk),
    .rst    (rst),
    .en     (active),
    .clr    (accept || !active),
    .tick   (tick)
  );

  always_ff @(posedge hw_clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      q     <= '0;
      term  <= '0;
    end else begin
      state <= state_next;
      q     <= q_next;
      term  <= term_next;
    end
  end

  always_comb begin
    state_next = state;
    q_next     = q;
    term_next  = term;
    if (accept) begin
      case (cmd_op)
        OP_LOAD:  q_next = cmd_data;
        OP_START: if (state == S_IDLE) state_next = S_RUN;
        OP_STOP:  state_next = S_IDLE;
        OP_ONESHOT: begin
          state_next = S_OS;
          term_next  = cmd_data;
        end
        default: ;
      endcase
    end else begin
      case (state)
        S_RUN:  if (tick) q_next = q_step;
        S_OS: begin
          if (tick) begin
            // Terminal is checked before stepping, so q stays at term.
            if (q == term) state_next = S_DONE;
            else           q_next     = q_step;
          end
        end
        S_DONE: state_next = S_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer
`timescale 1ns/1ps
module tb_counter_sequencer;
  import cnt_seq_pkg::*;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
  localparam int PS_W     = 14;

  logic             hw_clk = 1'b0;
  logic             rst;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] q;
  logic             running;
  logic             done;
`ifdef CNT_SEQ_DOWN_EN
  logic             cnt_dir = 1'b0;
`endif

  counter_sequencer #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) dut (
    .hw_clk    (hw_clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
`ifdef CNT_SEQ_DOWN_EN
    .cnt_dir   (cnt_dir),
`endif
    .q         (q),
    .running   (running),
    .done      (done)
  );

  always #41.665 hw_clk = ~hw_clk;

  int cyc = 0;
  always @(posedge hw_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         d;
    logic [7:0] v;
    int         c;
  } ev_t;
  ev_t exp_q[$];

  bit         mon_en = 1'b0;
  logic [7:0] last_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input bit d, input logic [7:0] v, input int c);
    ev_t e;
    e.d = d;
    e.v = v;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Monitor: an output event is any change of q or a done cycle.
  always @(negedge hw_clk) begin
    ev_t e;
    if (!mon_en) begin
      last_q = q;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: nothing seen, expected q=0x%0h done=%0d at cycle %0d",
                 exp_q[0].v, exp_q[0].d, exp_q[0].c);
        void'(exp_q.pop_front());
      end
      if (done || q !== last_q) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: q=0x%0h done=%0d at cycle %0d", q, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.c != cyc || e.d !== done || e.v !== q || (done && cmd_ready !== 1'b0)) begin
            n_fail++;
            $display("FAIL event: got q=0x%0h done=%0d ready=%0d cycle %0d, expected q=0x%0h done=%0d ready=%0d cycle %0d",
                     q, done, cmd_ready, cyc, e.v, e.d, !e.d, e.c);
          end
        end
      end
      last_q = q;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d, output int acc);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    acc       = cyc + 1;
    @(posedge hw_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge hw_clk);
      #1;
    end
  endtask

  initial begin
    int a, s, o, x;

    // Reset state
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("reset_q", 32'(q), 32'h00);
    check("reset_running", 32'(running), 32'h0);
    check("reset_ready", 32'(cmd_ready), 32'h1);
    check("reset_done", 32'(done), 32'h0);
    repeat (3) @(posedge hw_clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // LOAD 0xFE, START: wraps through 0xFF -> 0x00, 4 cycles per step
    issue(OP_LOAD, 8'hFE, a);
    expect_ev(0, 8'hFE, a);
    issue(OP_START, 8'h00, s);
    expect_ev(0, 8'hFF, s + 4);
    expect_ev(0, 8'h00, s + 8);
    wait_until(s + 9);
    issue(OP_STOP, 8'h00, x);
    check("stop_running", 32'(running), 32'h0);
    wait_until(x + 10);

    // STOP on a tick cycle: no increment
    issue(OP_LOAD, 8'h10, a);
    expect_ev(0, 8'h10, a);
    issue(OP_START, 8'h00, s);
    wait_until(s + 3);
    issue(OP_STOP, 8'h00, x);
    check("stop_on_tick_running", 32'(running), 32'h0);
    check("stop_on_tick_q", 32'(q), 32'h10);
    // Mid-period LOAD restarts the prescaler
    issue(OP_START, 8'h00, s);
    wait_until(s + 1);
    issue(OP_LOAD, 8'h20, x);
    expect_ev(0, 8'h20, x);
    expect_ev(0, 8'h21, x + 4);
    wait_until(x + 5);
    issue(OP_STOP, 8'h00, x);
    wait_until(x + 6);

    // LOAD 0x02, ONESHOT 0x05
    issue(OP_LOAD, 8'h02, a);
    expect_ev(0, 8'h02, a);
    issue(OP_ONESHOT, 8'h05, o);
    check("oneshot_running", 32'(running), 32'h1);
    expect_ev(0, 8'h03, o + 4);
    expect_ev(0, 8'h04, o + 8);
    expect_ev(0, 8'h05, o + 12);
    expect_ev(1, 8'h05, o + 16);
    wait_until(o + 18);
    check("oneshot_after_running", 32'(running), 32'h0);
    check("oneshot_after_q", 32'(q), 32'h05);
    check("oneshot_after_ready", 32'(cmd_ready), 32'h1);

    // ONESHOT with q already at terminal
    issue(OP_LOAD, 8'h07, a);
    expect_ev(0, 8'h07, a);
    issue(OP_ONESHOT, 8'h07, o);
    expect_ev(1, 8'h07, o + 4);
    wait_until(o + 6);
    check("os_equal_q", 32'(q), 32'h07);
    check("os_equal_running", 32'(running), 32'h0);

    // Direction
`ifdef CNT_SEQ_DOWN_EN
    cnt_dir = 1'b1;
`endif
    issue(OP_LOAD, 8'h01, a);
    expect_ev(0, 8'h01, a);
    issue(OP_START, 8'h00, s);
`ifdef CNT_SEQ_DOWN_EN
    expect_ev(0, 8'h00, s + 4);
    expect_ev(0, 8'hFF, s + 8);
`else
    expect_ev(0, 8'h02, s + 4);
    expect_ev(0, 8'h03, s + 8);
`endif
    wait_until(s + 9);
    issue(OP_STOP, 8'h00, x);
`ifdef CNT_SEQ_DOWN_EN
    cnt_dir = 1'b0;
`endif
    wait_until(x + 4);

    // Asynchronous reset mid-count
    issue(OP_LOAD, 8'h30, a);
    expect_ev(0, 8'h30, a);
    issue(OP_START, 8'h00, s);
    expect_ev(0, 8'h31, s + 4);
    wait_until(s + 6);
    #5;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'h00);
    check("async_rst_running", 32'(running), 32'h0);
    check("async_rst_ready", 32'(cmd_ready), 32'h1);
    check("async_rst_done", 32'(done), 32'h0);
    repeat (2) @(posedge hw_clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (12) @(posedge hw_clk);
    #1;
    check("post_rst_q_hold", 32'(q), 32'h00);
    check("post_rst_running", 32'(running), 32'h0);

    @(negedge hw_clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
